// File: rtl/quiz_pkg.sv
// Shared definitions for the quiz scoring engine.
//   state_t : controller state encoding, also exported on the debug state port
//   clog2   : ceiling log2 used to size index and round-counter fields
package quiz_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_OPEN   = 3'd1,
    S_LOCKED = 3'd2,
    S_SCAN   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/score_sat_update.sv
// Combinational score adjuster.
//   total  : current score (unsigned)
//   add    : 1 = add amount, saturating at all-ones; 0 = subtract, flooring at 0
//   amount : points to add or remove
//   result : adjusted score
module score_sat_update #(
  parameter int SCORE_W = 9
) (
  input  logic [SCORE_W-1:0] total,
  input  logic               add,
  input  logic [SCORE_W-1:0] amount,
  output logic [SCORE_W-1:0] result
);

  logic [SCORE_W:0] sum;

  always_comb begin
    sum = {1'b0, total} + {1'b0, amount};
    if (add) begin
      result = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
    end else begin
      result = (total < amount) ? '0 : (total - amount);
    end
  end

endmodule

// File: rtl/quiz_score_keeper.sv
// N-player quiz scoring engine: first-buzz arbitration, judged score update,
// round counting and an end-of-game sequential winner scan.
//   clk, rst       : rising-edge clock, asynchronous active-high reset
//   start          : begin a new game (honoured in IDLE or DONE only)
//   count          : remaining question time; zero means time expired
//   buzz           : per-player buzz level, lowest index wins the floor
//   judge_valid    : verdict strobe, right = 1 correct / 0 wrong
//   scores         : flat totals, player i at [i*SCORE_W +: SCORE_W]
//   buzz_locked    : a player holds the floor; buzzed_player is that player
//   round          : questions resolved so far in this game
//   finish         : game over, winner/tie valid
//   winner, tie    : highest-scoring player (lowest index on ties) and tie flag
//   dbg_state      : current controller state
//
// Handshake: judge_valid is a single-cycle strobe with no back-pressure; it is
// consumed only while a player is locked and is silently dropped otherwise.
// Every output comes straight from a flop or from a decode of the state flop.
module quiz_score_keeper
  import quiz_pkg::*;
#(
  parameter int NUM_PLAYERS = 4,
  parameter int SCORE_W     = 9,
  parameter int TIME_W      = 8,
  parameter int POINTS      = 10,
  parameter int PENALTY     = 5,
  parameter int NUM_ROUNDS  = 8,
  localparam int PLAYER_W   = clog2(NUM_PLAYERS),
  localparam int RND_W      = clog2(NUM_ROUNDS + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [TIME_W-1:0]              count,
  input  logic [NUM_PLAYERS-1:0]         buzz,
  input  logic                           judge_valid,
  input  logic                           right,
  output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
  output logic                           buzz_locked,
  output logic [PLAYER_W-1:0]            buzzed_player,
  output logic [RND_W-1:0]               round,
  output logic                           finish,
  output logic [PLAYER_W-1:0]            winner,
  output logic                           tie,
  output state_t                         dbg_state
);

  localparam logic [SCORE_W-1:0] POINTS_V  = SCORE_W'(POINTS);
  localparam logic [SCORE_W-1:0] PENALTY_V = SCORE_W'(PENALTY);

  state_t               state_q, state_d;
  logic [SCORE_W-1:0]   score_q [NUM_PLAYERS];
  logic [RND_W-1:0]     round_q, round_d;
  logic [PLAYER_W-1:0]  player_q, player_d;
  logic [PLAYER_W-1:0]  winner_q, winner_d;
  logic                 tie_q, tie_d;
  logic [PLAYER_W-1:0]  scan_idx_q, scan_idx_d;
  logic [SCORE_W-1:0]   best_q, best_d;

  logic                 clear_scores, score_we, upd_add;
  logic [SCORE_W-1:0]   upd_score, scan_score;
  logic [PLAYER_W-1:0]  buzz_idx;
  logic                 last_round;

  // Lowest set buzz bit wins: scan downward so the lowest index is written last.
  always_comb begin
    buzz_idx = '0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (buzz[i]) buzz_idx = PLAYER_W'(i);
    end
  end

  assign last_round = (round_q == RND_W'(NUM_ROUNDS - 1));
  assign scan_score = score_q[scan_idx_q];

  score_sat_update #(.SCORE_W(SCORE_W)) u_update (
    .total  (score_q[player_q]),
    .add    (upd_add),
    .amount (upd_add ? POINTS_V : PENALTY_V),
    .result (upd_score)
  );

  always_comb begin
    state_d      = state_q;
    round_d      = round_q;
    player_d     = player_q;
    winner_d     = winner_q;
    tie_d        = tie_q;
    scan_idx_d   = scan_idx_q;
    best_d       = best_q;
    clear_scores = 1'b0;
    score_we     = 1'b0;
    upd_add      = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d      = S_OPEN;
          clear_scores = 1'b1;
          round_d      = '0;
          winner_d     = '0;
          tie_d        = 1'b0;
        end
      end
      S_OPEN: begin
        // A buzz in the same cycle as time expiry takes the floor.
        if (|buzz) begin
          state_d  = S_LOCKED;
          player_d = buzz_idx;
        end else if (count == '0) begin
          round_d = round_q + 1'b1;
          state_d = last_round ? S_SCAN : S_OPEN;
        end
      end
      S_LOCKED: begin
        // Expiry without a verdict counts as wrong; a verdict always wins.
        if (judge_valid || (count == '0)) begin
          score_we = 1'b1;
          upd_add  = judge_valid & right;
          round_d  = round_q + 1'b1;
          state_d  = last_round ? S_SCAN : S_OPEN;
        end
      end
      S_SCAN: begin
        // Index 0 seeds the running best so a zero score is not a false tie.
        if (scan_idx_q == '0) begin
          best_d   = scan_score;
          winner_d = '0;
          tie_d    = 1'b0;
        end else if (scan_score > best_q) begin
          best_d   = scan_score;
          winner_d = scan_idx_q;
          tie_d    = 1'b0;
        end else if (scan_score == best_q) begin
          tie_d = 1'b1;
        end
        if (scan_idx_q == PLAYER_W'(NUM_PLAYERS - 1)) begin
          state_d    = S_DONE;
          scan_idx_d = '0;
        end else begin
          scan_idx_d = scan_idx_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      round_q    <= '0;
      player_q   <= '0;
      winner_q   <= '0;
      tie_q      <= 1'b0;
      scan_idx_q <= '0;
      best_q     <= '0;
      for (int i = 0; i < NUM_PLAYERS; i++) score_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      round_q    <= round_d;
      player_q   <= player_d;
      winner_q   <= winner_d;
      tie_q      <= tie_d;
      scan_idx_q <= scan_idx_d;
      best_q     <= best_d;
      if (clear_scores) begin
        for (int i = 0; i < NUM_PLAYERS; i++) score_q[i] <= '0;
      end else if (score_we) begin
        score_q[player_q] <= upd_score;
      end
    end
  end

  always_comb begin
    scores = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) scores[i*SCORE_W +: SCORE_W] = score_q[i];
  end

  assign buzz_locked   = (state_q == S_LOCKED);
  assign finish        = (state_q == S_DONE);
  assign buzzed_player = player_q;
  assign round         = round_q;
  assign winner        = winner_q;
  assign tie           = tie_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_quiz_score_keeper.sv
// Bench for quiz_score_keeper. Two instances share clock, reset and stimulus:
// dut plays short 3-round games; dut_b plays a 53-round game long enough to
// push a score into saturation. sel_big chooses which instance is observed.
module tb_quiz_score_keeper;

  localparam int NP   = 4;
  localparam int SW   = 9;
  localparam int TW   = 8;
  localparam int PTS  = 10;
  localparam int PEN  = 5;
  localparam int NR   = 3;
  localparam int NR_B = 53;
  localparam int PW   = 2;
  localparam int RW   = 2;
  localparam int RW_B = 6;
  localparam int SMAX = (1 << SW) - 1;

  // ---------------- clock / reset / signals ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, judge_valid, right;
  logic [TW-1:0] count;
  logic [NP-1:0] buzz;

  logic [NP*SW-1:0] scores, scores_b;
  logic             buzz_locked, buzz_locked_b, finish, finish_b, tie, tie_b;
  logic [PW-1:0]    buzzed_player, buzzed_player_b, winner, winner_b;
  logic [RW-1:0]    round;
  logic [RW_B-1:0]  round_b;
  logic [2:0]       dbg_state, dbg_state_b;

  quiz_score_keeper #(
    .NUM_PLAYERS(NP), .SCORE_W(SW), .TIME_W(TW), .POINTS(PTS),
    .PENALTY(PEN), .NUM_ROUNDS(NR)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .count(count), .buzz(buzz),
    .judge_valid(judge_valid), .right(right), .scores(scores),
    .buzz_locked(buzz_locked), .buzzed_player(buzzed_player), .round(round),
    .finish(finish), .winner(winner), .tie(tie), .dbg_state(dbg_state)
  );

  quiz_score_keeper #(
    .NUM_PLAYERS(NP), .SCORE_W(SW), .TIME_W(TW), .POINTS(PTS),
    .PENALTY(PEN), .NUM_ROUNDS(NR_B)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start), .count(count), .buzz(buzz),
    .judge_valid(judge_valid), .right(right), .scores(scores_b),
    .buzz_locked(buzz_locked_b), .buzzed_player(buzzed_player_b), .round(round_b),
    .finish(finish_b), .winner(winner_b), .tie(tie_b), .dbg_state(dbg_state_b)
  );

  logic             sel_big;
  logic [NP*SW-1:0] o_scores;
  logic [7:0]       o_round;
  logic             o_locked, o_finish, o_tie;
  logic [PW-1:0]    o_player, o_winner;
  logic [2:0]       o_state;

  always_comb begin
    if (sel_big) begin
      o_scores = scores_b;  o_round = 8'(round_b);  o_locked = buzz_locked_b;
      o_finish = finish_b;  o_tie = tie_b;  o_player = buzzed_player_b;
      o_winner = winner_b;  o_state = dbg_state_b;
    end else begin
      o_scores = scores;  o_round = 8'(round);  o_locked = buzz_locked;
      o_finish = finish;  o_tie = tie;  o_player = buzzed_player;
      o_winner = winner;  o_state = dbg_state;
    end
  end

  // ---------------- model + scoreboard ----------------
  int n_checks = 0;
  int n_err    = 0;
  int m_score [NP];
  int m_round;
  int m_player;
  logic [NP*SW+7:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NP*SW-1:0] pack_scores();
    logic [NP*SW-1:0] r;
    r = '0;
    for (int i = 0; i < NP; i++) r[i*SW +: SW] = SW'(m_score[i]);
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NP; i++) m_score[i] = 0;
    m_round = 0;
  endtask

  task automatic push_exp();
    exp_q.push_back({pack_scores(), 8'(m_round)});
  endtask

  task automatic pop_cmp(input string tag);
    logic [NP*SW+7:0] e;
    check({tag, "_pending"}, 64'(exp_q.size()), 64'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({tag, "_scores"}, 64'(o_scores), 64'(e[NP*SW+7:8]));
      check({tag, "_round"}, 64'(o_round), 64'(e[7:0]));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_count();
    count = TW'($urandom_range(1, 255));
  endtask

  task automatic do_start();
    start = 1'b1;
    model_clear();
    push_exp();
    tick();
    start = 1'b0;
    pop_cmp("start");
    check("start_finish", 64'(o_finish), 64'd0);
    check("start_winner", 64'(o_winner), 64'd0);
    check("start_tie", 64'(o_tie), 64'd0);
    check("start_state", 64'(o_state), 64'd1);
  endtask

  task automatic do_lock(input logic [NP-1:0] b, input int p, input bit cnt_zero);
    buzz = b;
    if (cnt_zero) count = '0;
    else idle_count();
    tick();
    buzz = '0;
    idle_count();
    check("lock_flag", 64'(o_locked), 64'd1);
    check("lock_player", 64'(o_player), 64'(p));
    check("lock_round", 64'(o_round), 64'(m_round));
    m_player = p;
  endtask

  // kind: 0 wrong, 1 right, 2 time expiry only, 3 right together with expiry
  task automatic do_verdict(input int kind);
    case (kind)
      0: begin judge_valid = 1'b1; right = 1'b0; end
      1: begin judge_valid = 1'b1; right = 1'b1; end
      2: count = '0;
      default: begin judge_valid = 1'b1; right = 1'b1; count = '0; end
    endcase
    if (kind == 1 || kind == 3) begin
      m_score[m_player] = (m_score[m_player] + PTS > SMAX) ? SMAX : m_score[m_player] + PTS;
    end else begin
      m_score[m_player] = (m_score[m_player] < PEN) ? 0 : m_score[m_player] - PEN;
    end
    m_round++;
    push_exp();
    tick();
    judge_valid = 1'b0;
    right = 1'b0;
    idle_count();
    pop_cmp("verdict");
    check("unlock", 64'(o_locked), 64'd0);
  endtask

  task automatic do_unanswered();
    buzz = '0;
    count = '0;
    m_round++;
    push_exp();
    tick();
    idle_count();
    pop_cmp("unanswered");
  endtask

  task automatic wait_done(input int exp_w, input bit exp_t);
    int c;
    c = 0;
    while (!o_finish && c < NP + 4) begin
      tick();
      c++;
    end
    check("scan_latency", 64'(c), 64'(NP));
    check("done_finish", 64'(o_finish), 64'd1);
    check("done_winner", 64'(o_winner), 64'(exp_w));
    check("done_tie", 64'(o_tie), 64'(exp_t));
    check("done_scores", 64'(o_scores), 64'(pack_scores()));
    check("done_round", 64'(o_round), 64'(m_round));
    tick();
    check("done_hold", 64'(o_finish), 64'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_scores"}, 64'(o_scores), 64'd0);
    check({tag, "_round"}, 64'(o_round), 64'd0);
    check({tag, "_locked"}, 64'(o_locked), 64'd0);
    check({tag, "_player"}, 64'(o_player), 64'd0);
    check({tag, "_finish"}, 64'(o_finish), 64'd0);
    check({tag, "_winner"}, 64'(o_winner), 64'd0);
    check({tag, "_tie"}, 64'(o_tie), 64'd0);
    check({tag, "_state"}, 64'(o_state), 64'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; start = 1'b0; buzz = '0; judge_valid = 1'b0; right = 1'b0;
    count = 8'd50; sel_big = 1'b0; m_player = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // buzz in IDLE does nothing
    buzz = 4'b0001;
    tick();
    buzz = '0;
    check("idle_no_lock", 64'(o_locked), 64'd0);
    check("idle_state", 64'(o_state), 64'd0);

    // game A
    do_start();
    judge_valid = 1'b1; right = 1'b1;
    push_exp();
    tick();
    judge_valid = 1'b0; right = 1'b0;
    pop_cmp("open_judge_ignored");
    check("open_judge_nolock", 64'(o_locked), 64'd0);

    do_lock(4'b0010, 1, 1'b0);
    do_verdict(1);                       // p1 = 10, round 1
    do_lock(4'b1010, 1, 1'b0);
    buzz = 4'b0001;
    tick();
    buzz = '0;
    check("locked_hold_player", 64'(o_player), 64'd1);
    check("locked_hold_flag", 64'(o_locked), 64'd1);
    do_verdict(0);                       // p1 = 5, round 2
    do_lock(4'b0001, 0, 1'b0);
    do_verdict(0);                       // p0 stays 0, round 3 -> scan
    wait_done(1, 1'b0);

    // game B
    do_start();
    do_unanswered();                     // round 1, no score change
    do_lock(4'b0100, 2, 1'b1);           // buzz beats expiry
    do_verdict(1);                       // p2 = 10, round 2
    do_lock(4'b1110, 1, 1'b0);
    do_verdict(3);                       // verdict beats expiry: p1 = 10, round 3
    wait_done(1, 1'b1);

    // game C: expiry penalty, start ignored in LOCKED, reset mid-scan
    do_start();
    do_lock(4'b1000, 3, 1'b0);
    do_verdict(1);                       // p3 = 10
    do_lock(4'b1000, 3, 1'b0);
    do_verdict(2);                       // p3 = 5
    do_lock(4'b1000, 3, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_in_locked_state", 64'(o_state), 64'd2);
    check("start_in_locked_scores", 64'(o_scores), 64'(pack_scores()));
    do_verdict(1);                       // p3 = 15, round 3 -> scan
    tick();
    tick();
    check("mid_scan_state", 64'(o_state), 64'd3);
    #2 rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    buzz = 4'b0001;
    repeat (3) tick();
    buzz = '0;
    check("post_rst_idle", 64'(o_state), 64'd0);
    check("post_rst_nolock", 64'(o_locked), 64'd0);

    // long game on dut_b: saturation at 511
    sel_big = 1'b1;
    do_start();
    for (int r = 0; r < 51; r++) begin
      do_lock(4'b0010, 1, 1'b0);
      do_verdict(1);                     // p1 climbs to 510
    end
    do_lock(4'b0110, 1, 1'b0);
    do_verdict(0);                       // 505
    do_lock(4'b0010, 1, 1'b0);
    do_verdict(1);                       // 511, saturated; last round
    wait_done(1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
